// File: rtl/l15_mem_responder.sv
// Memory-side responder for the L1.5 write-through cache interface.
// Serves tagged loads (full 128-bit lines) and stores (acks) from a local
// doubleword array with big-endian byte lanes. Every accepted request runs
// through a fixed-latency shift pipeline into an in-order return FIFO.
module l15_mem_responder #(
  parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
  parameter int          MEM_BYTES      = 8192,
  parameter int          TID_W          = 2,
  parameter int          LATENCY        = 2,
  parameter int          RTRN_DEPTH     = 8,
  parameter int          MAX_OUT_STORES = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_store_i,
  input  logic [TID_W-1:0] req_tid_i,
  input  logic [63:0]      req_addr_i,
  input  logic [63:0]      req_data_i,
  input  logic [7:0]       req_be_i,
  output logic             rtrn_valid_o,
  input  logic             rtrn_ready_i,
  output logic             rtrn_store_o,
  output logic [TID_W-1:0] rtrn_tid_o,
  output logic [127:0]     rtrn_data_o,
  output logic             rtrn_err_o
);
  localparam int WORDS = MEM_BYTES / 8;
  localparam int DW_W  = $clog2(WORDS);
  localparam int PTR_W = (RTRN_DEPTH > 1) ? $clog2(RTRN_DEPTH) : 1;
  localparam int CNT_W = $clog2(RTRN_DEPTH + 1);
  localparam int SUM_W = $clog2(RTRN_DEPTH + LATENCY + 1);
  localparam int ST_W  = $clog2(MAX_OUT_STORES + 1);

  typedef struct packed {
    logic             st;
    logic             err;
    logic [TID_W-1:0] tid;
    logic [127:0]     data;
  } rtrn_t;

  // Array byte k of a word is bits [8k+7:8k]; it is never reset.
  logic [63:0] mem [WORDS];

  function automatic logic [63:0] bswap(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RTRN_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [63:0]       w_off;
  logic              w_inrng, w_acc;
  logic [DW_W-1:0]   w_dw, w_ln_lo, w_ln_hi;
  rtrn_t             w_new, w_head;
  logic [LATENCY:1]  vld_pipe;
  rtrn_t             r_pipe [1:LATENCY];
  rtrn_t             r_fifo [RTRN_DEPTH];
  logic [PTR_W-1:0]  r_wr, r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [ST_W-1:0]   r_st_cnt;
  logic              r_en;
  logic [SUM_W-1:0]  w_infl;
  logic              w_space, w_push, w_pop, w_st_inc, w_st_dec;

  assign w_off   = req_addr_i - BASE_ADDR;
  assign w_inrng = (req_addr_i >= BASE_ADDR) && (w_off < 64'(MEM_BYTES));
  assign w_dw    = w_off[DW_W+2:3];
  assign w_ln_lo = {w_dw[DW_W-1:1], 1'b0};
  assign w_ln_hi = {w_dw[DW_W-1:1], 1'b1};
  assign w_acc   = req_valid_i && req_ready_o;

  // Build the return entry in the accept cycle; loads read the array here.
  always_comb begin
    w_new      = '0;
    w_new.st   = req_store_i;
    w_new.err  = !w_inrng;
    w_new.tid  = req_tid_i;
    if (!req_store_i && w_inrng)
      w_new.data = {bswap(mem[w_ln_hi]), bswap(mem[w_ln_lo])};
  end

  // Store write: data byte i lands in array byte 7-i; out-of-range is dropped.
  always_ff @(posedge clk_i) begin
    if (w_acc && req_store_i && w_inrng)
      for (int j = 0; j < 8; j++)
        if (req_be_i[7-j]) mem[w_dw][8*j +: 8] <= req_data_i[8*(7-j) +: 8];
  end

  // Valid shift register; never stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= w_acc;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Payload shift register; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    r_pipe[1] <= w_new;
    for (int i = 2; i <= LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
  end

  // Count in-flight pipeline entries for the space check.
  always_comb begin
    w_infl = '0;
    for (int i = 1; i <= LATENCY; i++) w_infl = w_infl + SUM_W'(vld_pipe[i]);
  end

  assign w_space = (w_infl + SUM_W'(r_cnt)) < SUM_W'(RTRN_DEPTH);
  assign w_push  = vld_pipe[LATENCY];
  assign w_pop   = rtrn_valid_o && rtrn_ready_i;

  // Return FIFO pointers and occupancy; count separates full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Return FIFO storage.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr] <= r_pipe[LATENCY];
  end

  assign w_head       = r_fifo[r_rd];
  assign rtrn_valid_o = (r_cnt != '0);
  assign rtrn_store_o = rtrn_valid_o && w_head.st;
  assign rtrn_err_o   = rtrn_valid_o && w_head.err;
  assign rtrn_tid_o   = rtrn_valid_o ? w_head.tid  : '0;
  assign rtrn_data_o  = rtrn_valid_o ? w_head.data : '0;

  assign w_st_inc = w_acc && req_store_i;
  assign w_st_dec = w_pop && w_head.st;

  // Outstanding-store credit; simultaneous accept and ack cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_st_cnt <= '0;
    else if (w_st_inc && !w_st_dec) r_st_cnt <= r_st_cnt + 1'b1;
    else if (w_st_dec && !w_st_inc) r_st_cnt <= r_st_cnt - 1'b1;
  end

  // Hold ready low through the first cycle after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_en <= 1'b0;
    else         r_en <= 1'b1;
  end

  assign req_ready_o = r_en && w_space && (r_st_cnt < ST_W'(MAX_OUT_STORES));
endmodule

// File: tb/tb_l15_mem_responder.sv
// Directed bench for l15_mem_responder with hand-computed expectations.
module tb_l15_mem_responder;
  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i, req_ready_o, req_store_i;
  logic [1:0]   req_tid_i;
  logic [63:0]  req_addr_i, req_data_i;
  logic [7:0]   req_be_i;
  logic         rtrn_valid_o, rtrn_ready_i, rtrn_store_o, rtrn_err_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] LINE80 = {64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000};
  localparam logic [127:0] LINE1FF0 = {64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444};

  l15_mem_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_tid_i(req_tid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_be_i(req_be_i),
    .rtrn_valid_o(rtrn_valid_o), .rtrn_ready_i(rtrn_ready_i), .rtrn_store_o(rtrn_store_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o), .rtrn_err_o(rtrn_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request and hold it until accepted.
  task automatic send(input logic st, input logic [1:0] tid, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] be);
    int n = 0;
    req_valid_i = 1'b1; req_store_i = st; req_tid_i = tid;
    req_addr_i = a; req_data_i = d; req_be_i = be;
    while (!req_ready_o && n < 100) begin tick(); n++; end
    if (n >= 100) chk("send_timeout", 128'(0), 128'(1));
    tick();
    req_valid_i = 1'b0;
  endtask

  // Wait for a return, check it, then pop it.
  task automatic expect_rtrn(input string tag, input logic st, input logic [1:0] tid,
                             input logic [127:0] d, input logic err);
    int n = 0;
    while (!rtrn_valid_o && n < 50) begin tick(); n++; end
    chk({tag, "_vld"},  128'(rtrn_valid_o), 128'(1));
    chk({tag, "_st"},   128'(rtrn_store_o), 128'(st));
    chk({tag, "_tid"},  128'(rtrn_tid_o),   128'(tid));
    chk({tag, "_data"}, rtrn_data_o,        d);
    chk({tag, "_err"},  128'(rtrn_err_o),   128'(err));
    rtrn_ready_i = 1'b1;
    tick();
    rtrn_ready_i = 1'b0;
  endtask

  initial begin
    logic [1:0] q[$];
    logic [1:0] etid;
    logic       acc;
    int         nacc, cnt;
    logic       exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] exp_t [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};

    rst_ni = 1'b0; req_valid_i = 1'b0; req_store_i = 1'b0; req_tid_i = '0;
    req_addr_i = '0; req_data_i = '0; req_be_i = '0; rtrn_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_outs", {125'(rtrn_data_o != 0), rtrn_valid_o, req_ready_o, rtrn_err_o}, 128'(0));
    rst_ni = 1'b1;
    chk("rst_first_rdy", 128'(req_ready_o), 128'(0));
    chk("rst_first_vld", 128'(rtrn_valid_o), 128'(0));
    tick();
    chk("rst_rdy_open", 128'(req_ready_o), 128'(1));

    // Endian round trip with partial write
    send(1'b1, 2'd0, 64'h8000_0088, 64'h0123_4567_89AB_CDEF, 8'hFF);
    expect_rtrn("pre_ack", 1'b1, 2'd0, '0, 1'b0);
    send(1'b1, 2'd1, 64'h8000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    send(1'b1, 2'd2, 64'h8000_0080, 64'h0, 8'h0F);
    send(1'b0, 2'd3, 64'h8000_0088, 64'h0, 8'h00);
    expect_rtrn("end_ack1", 1'b1, 2'd1, '0, 1'b0);
    expect_rtrn("end_ack2", 1'b1, 2'd2, '0, 1'b0);
    expect_rtrn("end_ld3",  1'b0, 2'd3, LINE80, 1'b0);

    // Latency and ordering: accepts at T, T+1, T+2; returns after T+2..T+4
    rtrn_ready_i = 1'b1;
    chk("lat_rdy", 128'(req_ready_o), 128'(1));
    for (int k = 0; k < 6; k++) begin
      req_valid_i = (k < 3); req_store_i = 1'b0; req_tid_i = 2'(k);
      req_addr_i = 64'h8000_0080;
      tick();
      chk($sformatf("lat_vld_%0d", k), 128'(rtrn_valid_o), 128'(exp_v[k]));
      if (exp_v[k]) begin
        chk($sformatf("lat_tid_%0d", k), 128'(rtrn_tid_o), 128'(exp_t[k]));
        chk($sformatf("lat_data_%0d", k), rtrn_data_o, LINE80);
      end
    end
    req_valid_i = 1'b0; rtrn_ready_i = 1'b0;

    // Store credit with returns blocked
    nacc = 0;
    for (int c = 0; c < 15; c++) begin
      req_valid_i = 1'b1; req_store_i = 1'b1; req_tid_i = 2'(nacc);
      req_addr_i = 64'h8000_0100; req_data_i = 64'(c); req_be_i = 8'hFF;
      acc = req_ready_o;
      tick();
      if (acc) begin q.push_back(2'(nacc)); nacc++; end
    end
    req_valid_i = 1'b0;
    chk("cred_acc", 128'(nacc), 128'(7));
    chk("cred_rdy0", 128'(req_ready_o), 128'(0));
    etid = q.pop_front();
    chk("cred_pop_tid", 128'(rtrn_tid_o), 128'(etid));
    rtrn_ready_i = 1'b1;
    tick();
    rtrn_ready_i = 1'b0;
    chk("cred_reopen", 128'(req_ready_o), 128'(1));
    // Same-cycle accept and ack pop
    etid = q.pop_front();
    chk("same_pop_tid", 128'(rtrn_tid_o), 128'(etid));
    req_valid_i = 1'b1; req_store_i = 1'b1; req_tid_i = 2'd3; rtrn_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0; rtrn_ready_i = 1'b0;
    q.push_back(2'd3);
    chk("same_rdy", 128'(req_ready_o), 128'(1));
    nacc = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid_i = 1'b1; req_tid_i = 2'd0;
      acc = req_ready_o;
      tick();
      if (acc) begin q.push_back(2'd0); nacc++; end
    end
    req_valid_i = 1'b0;
    chk("same_one_more", 128'(nacc), 128'(1));
    chk("same_qlen", 128'(q.size()), 128'(7));
    while (q.size() > 0) begin
      etid = q.pop_front();
      expect_rtrn("cred_drain", 1'b1, etid, '0, 1'b0);
    end

    // FIFO backpressure with continuous loads
    nacc = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid_i = 1'b1; req_store_i = 1'b0; req_tid_i = 2'(nacc);
      req_addr_i = 64'h8000_0080;
      acc = req_ready_o;
      tick();
      if (acc) nacc++;
    end
    req_valid_i = 1'b0;
    chk("bp_acc", 128'(nacc), 128'(8));
    chk("bp_rdy0", 128'(req_ready_o), 128'(0));
    for (int c = 0; c < 20; c++) begin
      chk("bp_hold", {rtrn_valid_o, rtrn_store_o, rtrn_tid_o, rtrn_err_o, rtrn_data_o[122:0]},
          {1'b1, 1'b0, 2'd0, 1'b0, LINE80[122:0]});
      tick();
    end
    rtrn_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_drain_%0d", i), 128'({rtrn_valid_o, rtrn_tid_o}), 128'({1'b1, 2'(i)}));
      tick();
    end
    chk("bp_empty", 128'(rtrn_valid_o), 128'(0));
    rtrn_ready_i = 1'b0;

    // Out of range
    send(1'b1, 2'd0, 64'h8000_1FF0, 64'h1111_2222_3333_4444, 8'hFF);
    expect_rtrn("oor_pre0", 1'b1, 2'd0, '0, 1'b0);
    send(1'b1, 2'd1, 64'h8000_1FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    expect_rtrn("oor_pre1", 1'b1, 2'd1, '0, 1'b0);
    send(1'b0, 2'd1, 64'h8000_2000, 64'h0, 8'h00);
    expect_rtrn("oor_ld", 1'b0, 2'd1, '0, 1'b1);
    send(1'b1, 2'd2, 64'h7FFF_FFF8, 64'h0, 8'hFF);
    expect_rtrn("oor_st", 1'b1, 2'd2, '0, 1'b1);
    send(1'b0, 2'd3, 64'h8000_1FF0, 64'h0, 8'h00);
    expect_rtrn("oor_keep", 1'b0, 2'd3, LINE1FF0, 1'b0);

    // Reset mid-flight: two returns pending, two loads in the pipeline
    for (int k = 0; k < 4; k++) send(1'b0, 2'(k), 64'h8000_0080, 64'h0, 8'h00);
    chk("mid_pending", 128'(rtrn_valid_o), 128'(1));
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_outs", {rtrn_data_o[122:0], rtrn_valid_o, req_ready_o, rtrn_store_o, rtrn_tid_o != 2'd0, rtrn_err_o}, 128'(0));
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rtrn_ready_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rtrn_valid_o) cnt++;
    end
    chk("mid_no_rtrn", 128'(cnt), 128'(0));
    rtrn_ready_i = 1'b0;
    send(1'b0, 2'd2, 64'h8000_0080, 64'h0, 8'h00);
    expect_rtrn("mid_survive", 1'b0, 2'd2, LINE80, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
